sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable responder for the external asynchronous-SRAM pin interface (CSX/OEX/WEX, 18-bit address, 16-bit bidirectional DATA). It sits on the device side of the bus and answers the SRAM controller from on-chip block RAM, so the controller can run on boards without the external chip and in loop-back benches. Reads drive DATA after a fixed latency. Writes commit when the write strobe is released.

## Interface
- `ADDR_W`, 18: pin address width.
- `DATA_W`, 16: data bus width.
- `MEM_ADDR_W`, 12: implemented depth is 2**MEM_ADDR_W words. Upper address bits are ignored, so addresses alias.
- `READ_LATENCY`, 2: cycles from read detection to DATA driven. Must be at least 1; elaboration fails otherwise.

Ports:
- `clk`, in, 1: single clock; all pins are sampled on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `address`, in, ADDR_W: word address.
- `DATA`, inout, DATA_W: driven only in the read-drive state, high-Z otherwise.
- `CSX`, in, 1: chip select, active low.
- `OEX`, in, 1: output enable, active low.
- `WEX`, in, 1: write enable, active low.
- `wr_commit`, out, 1: one-cycle pulse when a write is committed to memory.
- `protocol_err`, out, 1: one-cycle pulse on each edge that samples CSX=0, OEX=0 and WEX=0 together.

## Operation
- Pins are registered once into a sample stage; all decisions use the sampled values.
- A sampled condition is one of the following:
  - sel = ~CSX.
  - rd = sel & ~OEX & WEX.
  - wr = sel & ~WEX.
- The FSM has four states: IDLE, READ_WAIT, READ_DRIVE, WRITE.
- IDLE:
  - wr → WRITE.
  - rd → READ_WAIT, with the latency counter loaded to READ_LATENCY-1.
  - Otherwise stay in IDLE.
- READ_WAIT:
  - The memory read is issued at the latched address.
  - The counter decrements each edge. When it reaches 0 → READ_DRIVE.
  - If rd drops → IDLE.
  - If the sampled address changes → reload the counter and latch the new address; the latency restarts.
  - If wr appears → WRITE.
- READ_DRIVE:
  - DATA is driven with mem[address[MEM_ADDR_W-1:0]].
  - rd drops → IDLE, and DATA goes high-Z.
  - The address changes → READ_WAIT with the counter reloaded; DATA goes high-Z.
  - wr appears → WRITE, with DATA high-Z.
- WRITE:
  - Every edge latches the sampled address and DATA.
  - The edge that samples wr=0 writes the last latched pair into memory, pulses `wr_commit`, and moves → IDLE, or → READ_WAIT if rd is sampled on that edge.
- Priority: wr beats rd. When OEX and WEX are both low, the block behaves as a write, keeps DATA high-Z, and pulses `protocol_err`.
- CSX=1 means all pins are ignored. Releasing CSX during WRITE counts as the end of the strobe and commits the write.
- Memory contents are not reset and are X after configuration.

## Timing
- Reset values: state IDLE, DATA high-Z, `wr_commit`=0, `protocol_err`=0, sample stage cleared to the inactive pin levels (CSX=OEX=WEX=1).
- Reset asserted mid-operation: DATA goes high-Z asynchronously, and any pending uncommitted write is discarded.
- Read timing:
  - Let E0 be the first edge whose sample stage holds rd.
  - DATA is valid from just after edge E0+READ_LATENCY.
  - DATA stays valid while rd and the address are held.
  - The drive enable clears on the edge whose sample shows rd deasserted.
- Write timing:
  - The write commits on the edge whose sample shows WEX=1.
  - A read of the same address whose E0 equals the commit edge returns the new data. Read-after-write is exact because commit happens before the read issue.
- Throughput: one commit per strobe. The minimum strobe length is one sampled cycle.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (`SR_IDLE`, `SR_READ_WAIT`, `SR_READ_DRIVE`, `SR_WRITE`);
  - default width constants (`SRAM_ADDR_W`=18, `SRAM_DATA_W`=16).
- One sub-module, `sram_responder_mem`: a single-port synchronous block RAM of depth 2**MEM_ADDR_W with a one-cycle read latency and a write enable. The responder instantiates it once.
- The FSM, latency counter, sample stage, and tri-state driver stay in the top module.

## Test plan
- Write then read: drive a write of 0x1234 at 0x00005, then a read of 0x00005 → `wr_commit` pulses once; DATA=0x1234 from E0+2; DATA high-Z before that point.
- Aliasing, with MEM_ADDR_W=12: write 0xBEEF at 0x01005, read 0x00005 → 0xBEEF.
- Address change mid-read:
  - Preload 0x0010=0xAAAA and 0x0011=0x5555.
  - Hold OEX low at 0x0010 until DATA=0xAAAA, then switch to 0x0011.
  - Required: DATA high-Z for 2 cycles, then 0x5555.
- Contention: OEX=0 and WEX=0 together with DATA=0x00FF from the bench at 0x0020 → `protocol_err` pulses; the responder never drives DATA; 0x0020 later reads back 0x00FF.
- Reset mid-write:
  - Preload 0x0030=0x1111.
  - Start a write of 0x2222 at 0x0030 and assert rst_n=0 before WEX rises.
  - Required: DATA high-Z immediately, no `wr_commit`, and a later read of 0x0030 returns 0x1111.
- Deselect: CSX=1 with OEX=0 and WEX=0 toggling → no DATA drive, no pulses, memory unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and default widths for the async-SRAM responder.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    SR_IDLE       = 2'd0,
    SR_READ_WAIT  = 2'd1,
    SR_READ_DRIVE = 2'd2,
    SR_WRITE      = 2'd3
  } sr_state_e;

endpackage

// File: rtl/sram_responder_mem.sv
// Single-port synchronous block RAM with one-cycle read latency.
module sram_responder_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Device-side responder for an async-SRAM pin interface, backed by block RAM.
// Pins are registered once; every FSM decision uses the sampled copy.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int MEM_ADDR_W   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] DATA,
  input  logic              CSX,
  input  logic              OEX,
  input  logic              WEX,
  output logic              wr_commit,
  output logic              protocol_err
);

  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("sram_responder: READ_LATENCY must be at least 1");
  end

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  logic                  csx_q, oex_q, wex_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     din_q;
  sr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [MEM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  wr_commit_q, wr_commit_d;
  logic                  protocol_err_q, protocol_err_d;
  logic                  drive_q, drive_d;
  logic                  sel_s, rd_s, wr_s, clash_s, addr_chg_s;
  logic                  mem_we_s, mem_en_s;
  logic [MEM_ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0]     mem_rdata_s;

  // Pin sample stage; resets to the inactive pin levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csx_q  <= 1'b1;
      oex_q  <= 1'b1;
      wex_q  <= 1'b1;
      addr_q <= {ADDR_W{1'b0}};
      din_q  <= {DATA_W{1'b0}};
    end else begin
      csx_q  <= CSX;
      oex_q  <= OEX;
      wex_q  <= WEX;
      addr_q <= address;
      din_q  <= DATA;
    end
  end

  assign sel_s      = ~csx_q;
  assign rd_s       = sel_s & ~oex_q & wex_q;
  assign wr_s       = sel_s & ~wex_q;
  assign clash_s    = sel_s & ~oex_q & ~wex_q;
  assign addr_chg_s = (addr_q != rd_addr_q);

  // Next-state, latency counter, write latch and memory port control.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_s ? addr_q[MEM_ADDR_W-1:0] : wr_addr_q;
    wr_data_d      = wr_s ? din_q : wr_data_q;
    wr_commit_d    = 1'b0;
    protocol_err_d = clash_s;
    mem_we_s       = 1'b0;
    case (state_q)
      SR_IDLE: begin
        if (wr_s) begin
          state_d = SR_WRITE;
        end else if (rd_s) begin
          state_d   = SR_READ_WAIT;
          cnt_d     = CNT_LOAD;
          rd_addr_d = addr_q;
        end else begin
          state_d = SR_IDLE;
        end
      end
      SR_READ_WAIT: begin
        if (wr_s) begin
          state_d = SR_WRITE;
        end else if (!rd_s) begin
          state_d = SR_IDLE;
        end else if (addr_chg_s) begin
          cnt_d     = CNT_LOAD;
          rd_addr_d = addr_q;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = SR_READ_DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1'b1);
        end
      end
      SR_READ_DRIVE: begin
        if (wr_s) begin
          state_d = SR_WRITE;
        end else if (!rd_s) begin
          state_d = SR_IDLE;
        end else if (addr_chg_s) begin
          state_d   = SR_READ_WAIT;
          cnt_d     = CNT_LOAD;
          rd_addr_d = addr_q;
        end else begin
          state_d = SR_READ_DRIVE;
        end
      end
      SR_WRITE: begin
        // Strobe release commits the last latched pair before any read is issued.
        if (!wr_s) begin
          mem_we_s    = 1'b1;
          wr_commit_d = 1'b1;
          if (rd_s) begin
            state_d   = SR_READ_WAIT;
            cnt_d     = CNT_LOAD;
            rd_addr_d = addr_q;
          end else begin
            state_d = SR_IDLE;
          end
        end else begin
          state_d = SR_WRITE;
        end
      end
      default: begin
        state_d = SR_IDLE;
      end
    endcase
    drive_d = (state_d == SR_READ_DRIVE);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SR_IDLE;
      cnt_q          <= {CNT_W{1'b0}};
      rd_addr_q      <= {ADDR_W{1'b0}};
      wr_addr_q      <= {MEM_ADDR_W{1'b0}};
      wr_data_q      <= {DATA_W{1'b0}};
      wr_commit_q    <= 1'b0;
      protocol_err_q <= 1'b0;
      drive_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_commit_q    <= wr_commit_d;
      protocol_err_q <= protocol_err_d;
      drive_q        <= drive_d;
    end
  end

  assign mem_en_s   = mem_we_s | (state_q == SR_READ_WAIT) | (state_q == SR_READ_DRIVE);
  assign mem_addr_s = mem_we_s ? wr_addr_q : rd_addr_q[MEM_ADDR_W-1:0];

  sram_responder_mem #(
    .ADDR_W(MEM_ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en_s),
    .we   (mem_we_s),
    .addr (mem_addr_s),
    .wdata(wr_data_q),
    .rdata(mem_rdata_s)
  );

  assign DATA         = drive_q ? mem_rdata_s : {DATA_W{1'bz}};
  assign wr_commit    = wr_commit_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: reads push expected data and start cycle,
// a negedge monitor pops on each new DATA drive; pulses are counted against a model.
module tb_sram_responder;

  localparam int L  = 2;
  localparam int MW = 12;

  typedef struct packed {
    logic [15:0] data;
    int          cyc;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] address;
  logic        csx, oex, wex;
  logic        tb_oe;
  logic [15:0] tb_dout;
  wire  [15:0] data_w;
  logic        wr_commit, protocol_err;

  int tests = 0, fails = 0, cyc = 0;
  int commits_seen = 0, commits_exp = 0, perr_seen = 0, perr_exp = 0;
  rd_exp_t     exp_q[$];
  logic [15:0] model[int];
  logic [17:0] written_q[$];

  assign data_w = tb_oe ? tb_dout : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup pu (data_w[g]);
  end

  sram_responder #(.ADDR_W(18), .DATA_W(16), .MEM_ADDR_W(MW), .READ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .DATA(data_w),
    .CSX(csx), .OEX(oex), .WEX(wex), .wr_commit(wr_commit), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts pulses and checks every DUT drive against the scoreboard.
  initial begin : monitor
    rd_exp_t cur;
    logic    prev_drv, drv;
    prev_drv = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (wr_commit === 1'b1) commits_seen++;
      if (protocol_err === 1'b1) perr_seen++;
      drv = !tb_oe && (data_w !== 16'hFFFF);
      if (drv && !prev_drv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_drive", data_w, 16'hFFFF);
        end else begin
          cur = exp_q.pop_front();
          check("rd_data", data_w, cur.data);
          check("rd_start_cycle", cyc, cur.cyc);
        end
      end else if (drv) begin
        check("rd_hold", data_w, cur.data);
      end
      prev_drv = drv;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Read issued at the current negedge: data expected from cycle cyc+2+L.
  task automatic do_read(input logic [17:0] a, input int hold);
    csx = 1'b0; oex = 1'b0; wex = 1'b1; address = a;
    exp_q.push_back('{data: model[int'(a[MW-1:0])], cyc: cyc + 2 + L});
    repeat (hold) @(negedge clk);
    csx = 1'b1; oex = 1'b1;
    idle(3);
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int len,
                          input bit then_read);
    csx = 1'b0; oex = 1'b1; wex = 1'b0; address = a; tb_dout = d; tb_oe = 1'b1;
    repeat (len) @(negedge clk);
    model[int'(a[MW-1:0])] = d;
    commits_exp++;
    written_q.push_back(a);
    wex = 1'b1; tb_oe = 1'b0;
    if (then_read) begin
      do_read(a, L + 2);
    end else begin
      csx = 1'b1;
      idle(3);
    end
  endtask

  initial begin : stim
    logic [17:0] a;
    logic [15:0] d;
    int c0, p0;
    rst_n = 1'b0; csx = 1'b1; oex = 1'b1; wex = 1'b1;
    address = 18'h0; tb_oe = 1'b0; tb_dout = 16'h0;
    idle(3);
    check("reset_wr_commit", wr_commit, 1'b0);
    check("reset_protocol_err", protocol_err, 1'b0);
    check("reset_data_hiz", data_w, 16'hFFFF);
    rst_n = 1'b1;
    idle(2);

    // Write then read, plus aliasing through the ignored upper address bits.
    do_write(18'h00005, 16'h1234, 2, 1'b0);
    check("wr_commit_once", commits_seen, 1);
    do_read(18'h00005, L + 3);
    do_write(18'h01005, 16'hBEEF, 1, 1'b0);
    do_read(18'h00005, L + 2);
    do_write(18'h00007, 16'h7777, 1, 1'b1);

    // Address change while driving: two high-Z cycles, then the new word.
    do_write(18'h00010, 16'hAAAA, 1, 1'b0);
    do_write(18'h00011, 16'h5555, 1, 1'b0);
    csx = 1'b0; oex = 1'b0; wex = 1'b1; address = 18'h00010;
    exp_q.push_back('{data: 16'hAAAA, cyc: cyc + 2 + L});
    for (int i = 0; i < 20 && data_w !== 16'hAAAA; i++) @(negedge clk);
    check("chg_first_word", data_w, 16'hAAAA);
    address = 18'h00011;
    exp_q.push_back('{data: 16'h5555, cyc: cyc + 2 + L});
    idle(2);
    check("chg_hiz_1", data_w, 16'hFFFF);
    idle(1);
    check("chg_hiz_2", data_w, 16'hFFFF);
    idle(2);
    csx = 1'b1; oex = 1'b1;
    idle(3);

    // Contention: OEX and WEX low together behaves as a write.
    csx = 1'b0; oex = 1'b0; wex = 1'b0; address = 18'h00020; tb_dout = 16'h00FF; tb_oe = 1'b1;
    idle(2);
    csx = 1'b1; oex = 1'b1; wex = 1'b1; tb_oe = 1'b0;
    model[32'h20] = 16'h00FF; commits_exp++; perr_exp += 2;
    idle(3);
    check("clash_perr_count", perr_seen, perr_exp);
    do_read(18'h00020, L + 2);

    // Reset mid-write discards the write; reset mid-read releases DATA at once.
    do_write(18'h00030, 16'h1111, 1, 1'b0);
    csx = 1'b0; oex = 1'b1; wex = 1'b0; address = 18'h00030; tb_dout = 16'h2222; tb_oe = 1'b1;
    idle(2);
    #2 rst_n = 1'b0; tb_oe = 1'b0;
    #1 check("rst_write_hiz", data_w, 16'hFFFF);
    csx = 1'b1; wex = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("rst_no_commit", commits_seen, commits_exp);
    csx = 1'b0; oex = 1'b0; wex = 1'b1; address = 18'h00030;
    exp_q.push_back('{data: 16'h1111, cyc: cyc + 2 + L});
    for (int i = 0; i < 20 && data_w !== 16'h1111; i++) @(negedge clk);
    check("rst_old_data", data_w, 16'h1111);
    #2 rst_n = 1'b0;
    #1 check("rst_read_hiz", data_w, 16'hFFFF);
    csx = 1'b1; oex = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Deselected: strobes toggle with no effect.
    c0 = commits_seen; p0 = perr_seen;
    csx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      oex = 1'($urandom); wex = 1'($urandom); address = 18'($urandom);
      @(negedge clk);
    end
    oex = 1'b1; wex = 1'b1;
    idle(3);
    check("desel_no_commit", commits_seen, c0);
    check("desel_no_perr", perr_seen, p0);
    do_read(18'h00011, L + 1);

    // Randomized writes and aliased reads against the array model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 18'($urandom_range(0, 32'h3FFFF));
        d = 16'($urandom_range(0, 32'hFFFE));
        do_write(a, d, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      end else begin
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        a[17:MW] = 6'($urandom);
        do_read(a, L + 1 + int'($urandom_range(0, 3)));
      end
    end

    idle(4);
    check("final_commit_count", commits_seen, commits_exp);
    check("final_perr_count", perr_seen, perr_exp);
    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
